adder_seq_ctrl: RTL

//  Sequencer for the serial-load add/subtract lab datapath.
//  - Turns debounced button pulses into operand-A load steps: clear SIPO, shift WIDTH bits, launch the add.
//  - Waits out the registered adder latency, then captures result and overflow for the display and LEDs.
//  - Sits between the debouncer and the sipo/adder/display instances in the top level.

---
 rtl/adder_seq_ctrl_pkg.sv | 15 +
 rtl/idle_timer.sv | 38 +++
 rtl/adder_seq_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared state encoding and counter widths for the serial-load add/subtract sequencer.
// The state codes are also decoded by the display and LED debug logic.
package adder_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_ADD   = 3'd2,
        S_HOLD  = 3'd3
    } seqState_t;

    localparam int LAT_W   = 4;
    localparam int OPCNT_W = 8;

endpackage

// File: rtl/idle_timer.sv
// Down-counting inactivity timer: load opens a fresh TIMEOUT-cycle window and
// expire_o flags the cycle in which that window runs out while counting is enabled.
module idle_timer #(
    parameter int TIMEOUT = 100000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CW'(TIMEOUT - 1);
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A reload in the same cycle always beats expiry, so a late step is never lost.
    assign expire_o = en_i && !load_i && (count_q == '0);

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer for the serial-load add/subtract lab datapath: turns button steps into
// SIPO clear/shift pulses, waits out the adder latency and captures result/overflow.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int ADD_LAT = 1,
    parameter int TIMEOUT = 100000000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         step_i,
    input  logic                         mode_i,
    input  logic [WIDTH:0]               data_in_i,
    input  logic                         ov_in_i,
    output logic                         sipo_clr_o,
    output logic                         sipo_en_o,
    output logic                         add_sub_o,
    output logic [WIDTH:0]               result_o,
    output logic                         ov_o,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt_o,
    output logic [2:0]                   state_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [7:0]                   op_cnt_o
);

    localparam int BCW = $clog2(WIDTH + 1);

    seqState_t            state_q, state_d;
    logic [BCW-1:0]       bitCnt_q, bitCnt_d;
    logic [LAT_W-1:0]     latCnt_q, latCnt_d;
    logic                 sipoClr_q, sipoClr_d;
    logic                 sipoEn_q, sipoEn_d;
    logic                 addSub_q, addSub_d;
    logic [WIDTH:0]       result_q, result_d;
    logic                 ov_q, ov_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [OPCNT_W-1:0]   opCnt_q, opCnt_d;

    logic timerLoad;
    logic timerEn;
    logic timerExpire;
    logic lastBit;
    logic latDone;

    assign lastBit = (bitCnt_q == BCW'(WIDTH - 1));
    assign latDone = (latCnt_q == LAT_W'(ADD_LAT - 1));

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (timerLoad),
        .en_i     (timerEn),
        .expire_o (timerExpire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A step in SHIFT takes priority over a timer expiry landing on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (step_i) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (step_i) begin
                    if (lastBit) state_d = S_ADD;
                end else if (timerExpire) begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                if (latDone) state_d = S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sipoClr_d = 1'b0;
        sipoEn_d  = 1'b0;
        done_d    = 1'b0;
        addSub_d  = addSub_q;
        result_d  = result_q;
        ov_d      = ov_q;
        bitCnt_d  = bitCnt_q;
        latCnt_d  = latCnt_q;
        err_d     = err_q;
        opCnt_d   = opCnt_q;
        timerLoad = 1'b0;
        timerEn   = 1'b0;
        busy_d    = (state_d == S_SHIFT) || (state_d == S_ADD);
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (step_i) begin
                    sipoClr_d = 1'b1;
                    err_d     = 1'b0;
                    bitCnt_d  = '0;
                    timerLoad = 1'b1;
                end
            end
            S_SHIFT: begin
                timerEn = 1'b1;
                if (step_i) begin
                    sipoEn_d  = 1'b1;
                    bitCnt_d  = bitCnt_q + 1'b1;
                    timerLoad = 1'b1;
                    if (lastBit) begin
                        addSub_d = mode_i;
                        latCnt_d = '0;
                    end
                end else if (timerExpire) begin
                    err_d    = 1'b1;
                    bitCnt_d = '0;
                end
            end
            S_ADD: begin
                latCnt_d = latCnt_q + 1'b1;
                if (latDone) begin
                    result_d = data_in_i;
                    ov_d     = ov_in_i;
                    done_d   = 1'b1;
                    opCnt_d  = opCnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bitCnt_q  <= '0;
            latCnt_q  <= '0;
            sipoClr_q <= 1'b0;
            sipoEn_q  <= 1'b0;
            addSub_q  <= 1'b0;
            result_q  <= '0;
            ov_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            opCnt_q   <= '0;
        end else begin
            bitCnt_q  <= bitCnt_d;
            latCnt_q  <= latCnt_d;
            sipoClr_q <= sipoClr_d;
            sipoEn_q  <= sipoEn_d;
            addSub_q  <= addSub_d;
            result_q  <= result_d;
            ov_q      <= ov_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            opCnt_q   <= opCnt_d;
        end
    end

    assign sipo_clr_o = sipoClr_q;
    assign sipo_en_o  = sipoEn_q;
    assign add_sub_o  = addSub_q;
    assign result_o   = result_q;
    assign ov_o       = ov_q;
    assign bit_cnt_o  = bitCnt_q;
    assign state_o    = state_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign op_cnt_o   = opCnt_q;

endmodule
